mul_sched: RTL and testbench

//  Round-robin scheduler that shares one 8x8 sequential shift-add multiplier (start/fin, 17-bit O) among NREQ requesters.

---
 rtl/mul_sched_if.sv | 30 +++
 rtl/mul_sched.sv | 134 +++++++++++++
 tb/tb_mul_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sched_if.sv
// mul_sched_if: requester-side and multiplier-side signals of the mul_sched
// round-robin multiplier scheduler. The slave modport is the scheduler's view.
interface mul_sched_if #(
    parameter int unsigned NREQ = 4
);
    // requester side
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] a_in;
    logic [NREQ*8-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [16:0]       res_o;
    logic [NREQ-1:0]   res_vld;
    logic              err_o;
    // multiplier side
    logic [7:0]        m_a;
    logic [7:0]        m_b;
    logic              m_start;
    logic              m_fin;
    logic [16:0]       m_o;

    modport slave (
        input  req, a_in, b_in, m_fin, m_o,
        output gnt, res_o, res_vld, err_o, m_a, m_b, m_start
    );

    modport master (
        output req, a_in, b_in, m_fin, m_o,
        input  gnt, res_o, res_vld, err_o, m_a, m_b, m_start
    );
endinterface

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one 8x8 sequential multiplier
// (start/fin handshake, 17-bit product) among NREQ requesters.
// Optional feature: define MUL_TIMEOUT_EN to abort a WAIT that sees no m_fin
// within TMO_CYC cycles (err_o pulse, zero result). Without it err_o stays 0.
module mul_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TMO_CYC = 12
) (
    input  logic       ck,
    input  logic       rstn,
    mul_sched_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   rr_nx;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [NREQ-1:0] pick_oh;
    logic [7:0]      pick_a;
    logic [7:0]      pick_b;
    logic            tmo_hit;
    logic            err_q;

    // state register
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // round-robin search: first set req at or after rr, wrapping to 0
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!pick_vld && bus.req[IW'((32'(rr) + off) % NREQ)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((32'(rr) + off) % NREQ);
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = pick_vld;
        pick_a            = bus.a_in[8*pick_idx +: 8];
        pick_b            = bus.b_in[8*pick_idx +: 8];
        rr_nx             = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    // next-state logic; m_fin only matters in WAIT, so stale fins are ignored
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (pick_vld) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT:  if (bus.m_fin || tmo_hit) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // registered outputs: capture in IDLE, one-cycle start, result in WAIT, clear in DONE
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            bus.gnt     <= '0;
            bus.res_vld <= '0;
            bus.res_o   <= '0;
            bus.m_a     <= '0;
            bus.m_b     <= '0;
            bus.m_start <= 1'b0;
            err_q       <= 1'b0;
            rr          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        bus.gnt     <= pick_oh;
                        bus.m_a     <= pick_a;
                        bus.m_b     <= pick_b;
                        bus.m_start <= 1'b1;
                        rr          <= rr_nx;
                    end
                end
                ST_START: begin
                    bus.m_start <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.m_fin) begin
                        bus.res_o   <= bus.m_o;
                        bus.res_vld <= bus.gnt;
                    end else if (tmo_hit) begin
                        bus.res_o   <= '0;
                        bus.res_vld <= bus.gnt;
                        err_q       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    bus.res_vld <= '0;
                    bus.gnt     <= '0;
                    err_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.err_o = err_q;

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // WAIT cycle counter, cleared while in START so it starts at 0 on WAIT entry
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn)                              tmo_cnt <= '0;
        else if (state == ST_START)             tmo_cnt <= '0;
        else if (state == ST_WAIT && !tmo_hit)  tmo_cnt <= tmo_cnt + 1'b1;
    end

    // a fin arriving on the last allowed cycle still wins over the abort
    assign tmo_hit = (state == ST_WAIT) && !bus.m_fin && (tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: self-checking bench for mul_sched with a behavioural
// multiplier model and a scoreboard of expected grants/results.
module tb_mul_sched;
    localparam int unsigned NREQ = 4;

    logic ck   = 1'b0;
    logic rstn = 1'b1;

    mul_sched_if #(.NREQ(NREQ)) bus ();

    mul_sched #(.NREQ(NREQ), .TMO_CYC(12)) dut (
        .ck   (ck),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 ck = ~ck;

    typedef struct {
        int unsigned idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] prod;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        vec[8];
    int          checks    = 0;
    int          failures  = 0;
    int unsigned pops      = 0;
    int unsigned cyc       = 0;
    int unsigned grant_cyc = 0;
    int unsigned last_gnt  = 0;
    int unsigned exp_lat   = 10;
    bit          spacing_on = 1'b0;
    bit          have_last  = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;

    // multiplier model: loads on start, fin one cycle after 8 counting edges, never reset
    logic [7:0]  mul_a = '0;
    logic [7:0]  mul_b = '0;
    logic [3:0]  mcnt  = '0;
    logic        mbusy = 1'b0;
    logic        fin_r = 1'b0;
    logic [16:0] mo    = '0;
    logic        fin_block = 1'b0;
    logic        stray     = 1'b0;

    always @(posedge ck) begin
        if (bus.m_start) begin
            mul_a <= bus.m_a;
            mul_b <= bus.m_b;
            mcnt  <= 4'd1;
            mbusy <= 1'b1;
            fin_r <= 1'b0;
        end else if (mbusy) begin
            if (mcnt == 4'd8) begin
                fin_r <= 1'b1;
                mo    <= 17'(mul_a) * 17'(mul_b);
                mbusy <= 1'b0;
            end else begin
                mcnt  <= mcnt + 4'd1;
                fin_r <= 1'b0;
            end
        end else begin
            fin_r <= 1'b0;
        end
    end

    assign bus.m_fin = (fin_r & ~fin_block) | stray;
    assign bus.m_o   = mo;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"},     32'(bus.gnt),     0);
        chk({tag, "_res_vld"}, 32'(bus.res_vld), 0);
        chk({tag, "_res_o"},   32'(bus.res_o),   0);
        chk({tag, "_m_a"},     32'(bus.m_a),     0);
        chk({tag, "_m_b"},     32'(bus.m_b),     0);
        chk({tag, "_m_start"}, 32'(bus.m_start), 0);
        chk({tag, "_err_o"},   32'(bus.err_o),   0);
    endtask

    task automatic set_lane(input int unsigned i, input logic [7:0] a, input logic [7:0] b);
        bus.a_in[8*i +: 8] = a;
        bus.b_in[8*i +: 8] = b;
    endtask

    task automatic wait_gnt();
        int unsigned n = 0;
        while (bus.gnt == '0 && n < 10) begin
            @(negedge ck);
            n++;
        end
        chk("gnt_seen", 32'(bus.gnt != '0), 1);
    endtask

    // wait for n results; optionally each requester drops req on its own res_vld
    task automatic run(input int unsigned n, input bit clr);
        int unsigned target = pops + n;
        int unsigned budget = 0;
        while (pops < target && budget < 20*n + 40) begin
            @(negedge ck);
            budget++;
            if (clr) bus.req = bus.req & ~bus.res_vld;
        end
        chk("ops_done", 32'(pops >= target), 1);
    endtask

    // monitor: grant-rise checks against queue head, result checks on pop
    always @(negedge ck) begin
        exp_t e;
        if (rstn) begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                grant_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("gnt_unexpected", 32'(bus.gnt), 0);
                end else begin
                    chk("gnt", 32'(bus.gnt), 32'(1) << sb[0].idx);
                    chk("m_a", 32'(bus.m_a), 32'(sb[0].a));
                    chk("m_b", 32'(bus.m_b), 32'(sb[0].b));
                end
                chk("m_start_on", 32'(bus.m_start), 1);
                if (spacing_on && have_last) chk("spacing", grant_cyc - last_gnt, 12);
                last_gnt  = grant_cyc;
                have_last = 1'b1;
            end else begin
                chk("m_start_off", 32'(bus.m_start), 0);
            end
            if (bus.res_vld != '0) begin
                if (sb.size() == 0) begin
                    chk("vld_unexpected", 32'(bus.res_vld), 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_vld",    32'(bus.res_vld), 32'(1) << e.idx);
                    chk("res_o",      32'(bus.res_o),   32'(e.prod));
                    chk("err_o",      32'(bus.err_o),   32'(e.err));
                    chk("gnt_at_vld", 32'(bus.gnt),     32'(bus.res_vld));
                    chk("latency",    cyc - grant_cyc,  exp_lat);
                    pops++;
                end
            end else begin
                chk("err_quiet", 32'(bus.err_o), 0);
            end
        end
        prev_gnt = bus.gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        exp_t        t;
        logic [7:0]  ta[4];
        logic [7:0]  tb_[4];

        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge ck);
        check_reset("rst");
        rstn = 1'b1;

        // single-requester vectors; last one on lane 3 leaves rr at 0
        vec[0] = '{0, 8'd3,   8'd5,   17'd15,     1'b0};
        vec[1] = '{0, 8'd255, 8'd255, 17'h0FE01,  1'b0};
        vec[2] = '{1, 8'd0,   8'd0,   17'd0,      1'b0};
        vec[3] = '{2, 8'd255, 8'd1,   17'd255,    1'b0};
        vec[4] = '{1, 8'd17,  8'd15,  17'd255,    1'b0};
        vec[5] = '{2, 8'd0,   8'd200, 17'd0,      1'b0};
        vec[6] = '{0, 8'd12,  8'd12,  17'd144,    1'b0};
        vec[7] = '{3, 8'd128, 8'd2,   17'd256,    1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            set_lane(vec[i].idx, vec[i].a, vec[i].b);
            sb.push_back(vec[i]);
            bus.req = '0;
            bus.req[vec[i].idx] = 1'b1;
            wait_gnt();
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            run(1, 1'b1);
            bus.req = '0;
        end

        // all four requesting: 0,1,2,3,0 at 12-cycle spacing
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 8'(23 + 50*i);
            tb_[i] = 8'(250 - 31*i);
            set_lane(i, ta[i], tb_[i]);
        end
        for (int k = 0; k < 5; k++) begin
            t = '{k % 4, ta[k % 4], tb_[k % 4], 17'(ta[k % 4]) * 17'(tb_[k % 4]), 1'b0};
            sb.push_back(t);
        end
        have_last  = 1'b0;
        spacing_on = 1'b1;
        bus.req = 4'hF;
        run(5, 1'b0);
        bus.req = '0;
        spacing_on = 1'b0;

        // move rr to 2, then req=0011 must wrap to 0 before 1
        set_lane(1, 8'd6, 8'd7);
        sb.push_back('{1, 8'd6, 8'd7, 17'd42, 1'b0});
        bus.req = 4'b0010;
        run(1, 1'b1);
        bus.req = '0;
        set_lane(0, 8'd11, 8'd13);
        set_lane(1, 8'd200, 8'd3);
        sb.push_back('{0, 8'd11,  8'd13, 17'd143, 1'b0});
        sb.push_back('{1, 8'd200, 8'd3,  17'd600, 1'b0});
        bus.req = 4'b0011;
        run(2, 1'b1);
        bus.req = '0;

        // reset during WAIT of a lane-2 op (leaves rr=3 if not reset)
        set_lane(2, 8'd9, 8'd9);
        sb.push_back('{2, 8'd9, 8'd9, 17'd81, 1'b0});
        bus.req = 4'b0100;
        wait_gnt();
        repeat (4) @(negedge ck);
        #3 rstn = 1'b0;
        #1 check_reset("rst_mid");
        sb.delete();
        bus.req = '0;
        @(negedge ck);
        @(negedge ck);
        rstn = 1'b1;
        stray = 1'b1;
        repeat (2) @(negedge ck);
        stray = 1'b0;
        set_lane(1, 8'd7, 8'd9);
        set_lane(3, 8'd4, 8'd4);
        sb.push_back('{1, 8'd7, 8'd9, 17'd63, 1'b0});
        sb.push_back('{3, 8'd4, 8'd4, 17'd16, 1'b0});
        bus.req = 4'b1010;
        wait_gnt();
        stray = 1'b1;
        @(negedge ck);
        stray = 1'b0;
        run(2, 1'b1);
        bus.req = '0;

`ifdef MUL_TIMEOUT_EN
        // fin never arrives: abort after 12 WAIT cycles, then normal service
        fin_block = 1'b1;
        exp_lat   = 13;
        set_lane(0, 8'd5, 8'd5);
        sb.push_back('{0, 8'd5, 8'd5, 17'd0, 1'b1});
        bus.req = 4'b0001;
        run(1, 1'b1);
        bus.req   = '0;
        fin_block = 1'b0;
        exp_lat   = 10;
        set_lane(1, 8'd2, 8'd3);
        sb.push_back('{1, 8'd2, 8'd3, 17'd6, 1'b0});
        bus.req = 4'b0010;
        run(1, 1'b1);
        bus.req = '0;
`endif

        repeat (3) @(negedge ck);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
